// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer driving one external combinational full adder.
// Operands are stepped LSB-first, one bit per clock; the sum is published on a done pulse.
module serial_adder_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             fa_in_1,
    output logic             fa_in_2,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_count,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic [WIDTH-1:0]   sum_sh_q;
    logic [WIDTH-1:0]   sum_d;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   result_q;
    logic               cout_q;
    logic               busy_q;
    logic               done_q;

    // Partial sum lives in its own shift register so result stays 0 until done.
    always_comb begin
        sum_d            = sum_sh_q >> 1;
        sum_d[WIDTH-1]   = fa_sum;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge regardless of order.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q   <= op_a;
                        b_sh_q   <= op_b;
                        carry_q  <= cin;
                        cnt_q    <= '0;
                        sum_sh_q <= '0;
                        result_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    sum_sh_q <= sum_d;
                    carry_q  <= fa_count;
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        result_q <= sum_d;
                        cout_q   <= fa_count;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Adder inputs are only live while stepping; otherwise held at 0.
    assign fa_in_1 = (state_q == RUN) & a_sh_q[0];
    assign fa_in_2 = (state_q == RUN) & b_sh_q[0];
    assign fa_cin  = (state_q == RUN) & carry_q;

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1, each DUT
// paired with a behavioural full adder.
module tb_serial_adder_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;

    // WIDTH=8 instance
    logic       start8 = 1'b0;
    logic [7:0] op_a8 = '0, op_b8 = '0;
    logic       cin8 = 1'b0;
    logic       fa8_in_1, fa8_in_2, fa8_cin, fa8_sum, fa8_count;
    logic       busy8, done8, cout8;
    logic [7:0] result8;

    // WIDTH=1 instance
    logic       start1 = 1'b0;
    logic [0:0] op_a1 = '0, op_b1 = '0;
    logic       cin1 = 1'b0;
    logic       fa1_in_1, fa1_in_2, fa1_cin, fa1_sum, fa1_count;
    logic       busy1, done1, cout1;
    logic [0:0] result1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 sys_clk = ~sys_clk;

    assign fa8_sum   = fa8_in_1 ^ fa8_in_2 ^ fa8_cin;
    assign fa8_count = (fa8_in_1 & fa8_in_2) | (fa8_in_1 & fa8_cin) | (fa8_in_2 & fa8_cin);
    assign fa1_sum   = fa1_in_1 ^ fa1_in_2 ^ fa1_cin;
    assign fa1_count = (fa1_in_1 & fa1_in_2) | (fa1_in_1 & fa1_cin) | (fa1_in_2 & fa1_cin);

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .sys_clk (sys_clk),  .sys_rst (sys_rst),
        .start   (start8),   .op_a    (op_a8),    .op_b   (op_b8),   .cin (cin8),
        .fa_in_1 (fa8_in_1), .fa_in_2 (fa8_in_2), .fa_cin (fa8_cin),
        .fa_sum  (fa8_sum),  .fa_count(fa8_count),
        .busy    (busy8),    .done    (done8),    .result (result8), .cout (cout8)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .sys_clk (sys_clk),  .sys_rst (sys_rst),
        .start   (start1),   .op_a    (op_a1),    .op_b   (op_b1),   .cin (cin1),
        .fa_in_1 (fa1_in_1), .fa_in_2 (fa1_in_2), .fa_cin (fa1_cin),
        .fa_sum  (fa1_sum),  .fa_count(fa1_count),
        .busy    (busy1),    .done    (done1),    .result (result1), .cout (cout1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One WIDTH=8 add. repulse_at/rst_at (0 = unused) pick the post-start
    // cycle in which a second start or a one-cycle reset is injected.
    task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] exp_r, input logic exp_c,
                        input int repulse_at, input int rst_at, input string tag);
        int dones = 0;
        int first = 0;
        @(negedge sys_clk);
        op_a8 = a; op_b8 = b; cin8 = c; start8 = 1'b1;
        @(posedge sys_clk);
        #1 start8 = 1'b0;
        for (int j = 1; j <= 14; j++) begin
            @(negedge sys_clk);
            if (done8) begin
                dones++;
                if (first == 0) first = j;
            end
            if (j == 1) begin
                check({tag, "_res_zero_run"}, 32'(result8), 32'h0);
                check({tag, "_fa_run"}, {29'd0, fa8_in_1, fa8_in_2, fa8_cin}, {29'd0, a[0], b[0], c});
            end
            if (rst_at != 0 && j == rst_at + 1) begin
                check({tag, "_rst_outs"},
                      {22'd0, busy8, done8, result8, cout8, fa8_in_1, fa8_in_2, fa8_cin}, 32'h0);
                sys_rst = 1'b0;
            end
            if (rst_at == 0) begin
                if (j == 4 || j == 9 || j == 10)
                    check({tag, "_busy"}, 32'(busy8), 32'(j <= 9));
                if (j >= 9)
                    check({tag, "_fa_idle"}, {29'd0, fa8_in_1, fa8_in_2, fa8_cin}, 32'h0);
            end
            if (j == repulse_at) begin
                op_a8 = 8'h11; op_b8 = 8'h22; start8 = 1'b1;
            end
            if (j == repulse_at + 1) start8 = 1'b0;
            if (j == rst_at) sys_rst = 1'b1;
        end
        if (rst_at == 0) begin
            check({tag, "_latency"}, 32'(first), 32'd9);
            check({tag, "_dones"}, 32'(dones), 32'd1);
            check({tag, "_result"}, 32'(result8), 32'(exp_r));
            check({tag, "_cout"}, 32'(cout8), 32'(exp_c));
        end else begin
            check({tag, "_no_done"}, 32'(dones), 32'd0);
        end
    endtask

    // One WIDTH=1 add; returns as soon as done is seen so the next call
    // issues its start in the following IDLE cycle (back-to-back rate).
    task automatic add1(input logic a, input logic b, input logic c, input string tag);
        int first = 0;
        logic [1:0] exp;
        exp = 2'(a) + 2'(b) + 2'(c);
        @(negedge sys_clk);
        op_a1 = a; op_b1 = b; cin1 = c; start1 = 1'b1;
        @(posedge sys_clk);
        #1 start1 = 1'b0;
        for (int j = 1; j <= 5 && first == 0; j++) begin
            @(negedge sys_clk);
            if (done1) first = j;
        end
        check({tag, "_latency"}, 32'(first), 32'd2);
        check({tag, "_sum"}, {30'd0, cout1, result1}, 32'(exp));
    endtask

    initial begin
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        check("reset_outs8",
              {22'd0, busy8, done8, result8, cout8, fa8_in_1, fa8_in_2, fa8_cin}, 32'h0);
        check("reset_outs1",
              {25'd0, busy1, done1, result1, cout1, fa1_in_1, fa1_in_2, fa1_cin}, 32'h0);
        sys_rst = 1'b0;

        add8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0, 0, "add_5a_3c");
        add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 0, "add_ff_01");
        add8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0, 0, "add_ff_ff_c1");
        add8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 3, 0, "ignore_start");
        add8(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 0, 0, "add_ff_ff_c0");
        add8(8'h5A, 8'h3C, 1'b0, 8'h00, 1'b0, 0, 4, "abort_rst");
        add8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0, 0, "add_80_80");

        add1(1'b1, 1'b1, 1'b1, "w1_1p1c1");
        for (int v = 0; v < 1000; v++) begin
            logic [2:0] r;
            r = 3'($urandom_range(0, 7));
            add1(r[0], r[1], r[2], "w1_rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
